// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit multi-cycle CPU control path.
// Opcodes, ALU control encodings and sequencer state codes.
package cpu16_pkg;

  localparam logic [3:0] OP_RLOG  = 4'b0000;
  localparam logic [3:0] OP_RADD  = 4'b0001;
  localparam logic [3:0] OP_SHIFT = 4'b0010;
  localparam logic [3:0] OP_ADDI  = 4'b1001;
  localparam logic [3:0] OP_SUBI  = 4'b1010;
  localparam logic [3:0] OP_SLTI  = 4'b1011;
  localparam logic [3:0] OP_LW    = 4'b1100;
  localparam logic [3:0] OP_SW    = 4'b1101;
  localparam logic [3:0] OP_BNE   = 4'b1110;
  localparam logic [3:0] OP_BEQ   = 4'b1111;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_ITYPE = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    SRCB_REG  = 2'b00,
    SRCB_ONE  = 2'b01,
    SRCB_IMM  = 2'b10,
    SRCB_BOFF = 2'b11
  } srcb_e;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_TRAP
  } state_e;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Sequencer <-> datapath/memory control bundle.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_sequencer_if;
  logic       Run;
  logic [3:0] OPCODE;
  logic       Zero;
  logic       MemReady;
  logic       MemReq;
  logic       MemWE;
  logic       IorD;
  logic       IRWrite;
  logic       PCWrite;
  logic       PCSource;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       RegDst;
  logic       MemToReg;
  logic       RegWrite;
  logic       InstrDone;
  logic       Illegal;
  logic       BusError;

  modport master (
    input  Run, OPCODE, Zero, MemReady,
    output MemReq, MemWE, IorD, IRWrite,
    output PCWrite, PCSource, ALUSrcA, ALUSrcB,
    output ALUOp, RegDst, MemToReg, RegWrite,
    output InstrDone, Illegal, BusError
  );

  modport slave (
    output Run, OPCODE, Zero, MemReady,
    input  MemReq, MemWE, IorD, IRWrite,
    input  PCWrite, PCSource, ALUSrcA, ALUSrcB,
    input  ALUOp, RegDst, MemToReg, RegWrite,
    input  InstrDone, Illegal, BusError
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; expired_o flags the wait cycle that
// exhausts the budget (never asserted when MEM_TIMEOUT is 0).
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_W       = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int LIM = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [TMR_W-1:0] LIMIT = LIM[TMR_W-1:0];

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expired_o = (MEM_TIMEOUT != 0) && enable_i
                     && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback control FSM
// for the 16-bit CPU, with memory wait timeout trap.
module multicycle_sequencer
  import cpu16_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_W       = 8
) (
  input logic Clock,
  input logic Reset_n,
  multicycle_sequencer_if.master bus
);

  state_e state_q, state_d;
  logic   fpend_q, fpend_d;
  logic   ill_q, ill_d;
  logic   berr_q, berr_d;

  logic   mem_req, tmo;
  logic   mwe, iord, irw, pcw, pcsrc, srca;
  logic   regdst, m2r, rw, done;
  srcb_e  srcb;
  aluop_e aluop;

  // A started fetch stays requested even if Run drops.
  assign mem_req = (state_q == S_FETCH && (bus.Run || fpend_q))
                   || state_q == S_MEM_RD
                   || state_q == S_MEM_WR;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMR_W      (TMR_W)
  ) u_tmr (
    .clk_i    (Clock),
    .rst_ni   (Reset_n),
    .clear_i  (state_d != state_q),
    .enable_i (mem_req && !bus.MemReady),
    .expired_o(tmo)
  );

  always_comb begin
    state_d = state_q;
    fpend_d = 1'b0;
    ill_d   = ill_q;
    berr_d  = berr_q;
    mwe     = 1'b0;
    iord    = 1'b0;
    irw     = 1'b0;
    pcw     = 1'b0;
    pcsrc   = 1'b0;
    srca    = 1'b0;
    srcb    = SRCB_REG;
    aluop   = ALU_ADD;
    regdst  = 1'b0;
    m2r     = 1'b0;
    rw      = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        srcb = SRCB_ONE;
        if (mem_req && bus.MemReady) begin
          irw     = 1'b1;
          pcw     = 1'b1;
          state_d = S_DECODE;
        end else if (tmo) begin
          berr_d  = 1'b1;
          state_d = S_TRAP;
        end else begin
          fpend_d = mem_req;
        end
      end
      S_DECODE: begin
        srcb = SRCB_BOFF;
        unique case (bus.OPCODE)
          OP_RLOG, OP_RADD, OP_SHIFT: state_d = S_EXEC_R;
          OP_ADDI, OP_SUBI, OP_SLTI:  state_d = S_EXEC_I;
          OP_LW, OP_SW:               state_d = S_ADDR;
          OP_BNE, OP_BEQ:             state_d = S_BRANCH;
          default: begin
            ill_d   = 1'b1;
            state_d = S_TRAP;
          end
        endcase
      end
      S_EXEC_R: begin
        srca    = 1'b1;
        aluop   = ALU_RTYPE;
        state_d = S_WB_R;
      end
      S_WB_R: begin
        regdst  = 1'b1;
        rw      = 1'b1;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_EXEC_I: begin
        srca    = 1'b1;
        srcb    = SRCB_IMM;
        aluop   = ALU_ITYPE;
        state_d = S_WB_I;
      end
      S_WB_I: begin
        rw      = 1'b1;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDR: begin
        srca    = 1'b1;
        srcb    = SRCB_IMM;
        state_d = (bus.OPCODE == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        iord = 1'b1;
        if (bus.MemReady) begin
          state_d = S_WB_MEM;
        end else if (tmo) begin
          berr_d  = 1'b1;
          state_d = S_TRAP;
        end
      end
      S_WB_MEM: begin
        m2r     = 1'b1;
        rw      = 1'b1;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_WR: begin
        mwe  = 1'b1;
        iord = 1'b1;
        if (bus.MemReady) begin
          done    = 1'b1;
          state_d = S_FETCH;
        end else if (tmo) begin
          berr_d  = 1'b1;
          state_d = S_TRAP;
        end
      end
      S_BRANCH: begin
        srca    = 1'b1;
        aluop   = ALU_SUB;
        pcsrc   = 1'b1;
        pcw     = (bus.OPCODE == OP_BEQ) ? bus.Zero : !bus.Zero;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= S_FETCH;
      fpend_q <= 1'b0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fpend_q <= fpend_d;
      ill_q   <= ill_d;
      berr_q  <= berr_d;
    end
  end

  assign bus.MemReq    = Reset_n & mem_req;
  assign bus.MemWE     = Reset_n & mwe;
  assign bus.IorD      = Reset_n & iord;
  assign bus.IRWrite   = Reset_n & irw;
  assign bus.PCWrite   = Reset_n & pcw;
  assign bus.PCSource  = Reset_n & pcsrc;
  assign bus.ALUSrcA   = Reset_n & srca;
  assign bus.ALUSrcB   = {2{Reset_n}} & srcb;
  assign bus.ALUOp     = {2{Reset_n}} & aluop;
  assign bus.RegDst    = Reset_n & regdst;
  assign bus.MemToReg  = Reset_n & m2r;
  assign bus.RegWrite  = Reset_n & rw;
  assign bus.InstrDone = Reset_n & done;
  assign bus.Illegal   = Reset_n & ill_q;
  assign bus.BusError  = Reset_n & berr_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: latencies, handshakes,
// branch qualification, timeout and illegal-opcode traps.
module tb_multicycle_sequencer;
  import cpu16_pkg::*;

  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clock = ~Clock;

  multicycle_sequencer_if bus ();

  multicycle_sequencer #(
    .MEM_TIMEOUT(16),
    .TMR_W      (8)
  ) dut (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  int n;
  int cnt;
  logic saw;

  wire [16:0] outs = {bus.MemReq, bus.MemWE, bus.IorD, bus.IRWrite,
                      bus.PCWrite, bus.PCSource, bus.ALUSrcA,
                      bus.ALUSrcB, bus.ALUOp, bus.RegDst,
                      bus.MemToReg, bus.RegWrite, bus.InstrDone,
                      bus.Illegal, bus.BusError};

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Runs from the FETCH cycle until InstrDone (bounded); stays in
  // the done cycle. n counts cycles including FETCH.
  task automatic run_instr(input logic [3:0] op, input logic z,
                           output int cyc, output logic pcs);
    bus.OPCODE   = op;
    bus.Zero     = z;
    bus.MemReady = 1'b1;
    cyc = 1;
    pcs = 1'b0;
    #1;
    while (!bus.InstrDone && cyc < 40) begin
      if (bus.PCSource) pcs = 1'b1;
      tick();
      cyc++;
    end
    if (bus.PCSource) pcs = 1'b1;
  endtask

  initial begin
    bus.Run      = 1'b1;
    bus.MemReady = 1'b1;
    bus.OPCODE   = OP_ADDI;
    bus.Zero     = 1'b0;
    Reset_n      = 1'b0;
    tick();
    tick();
    chk("reset_outs", 32'(outs), 32'd0);

    Reset_n = 1'b1;
    #1;
    chk("rel_fetch", 32'({bus.MemReq, bus.IorD, bus.ALUSrcB}),
        32'b1001);

    run_instr(OP_ADDI, 1'b0, n, saw);
    chk("addi_lat", 32'(n), 32'd4);
    chk("addi_wb", 32'({bus.RegWrite, bus.RegDst}), 32'b10);
    tick();

    run_instr(OP_LW, 1'b0, n, saw);
    chk("lw_lat", 32'(n), 32'd5);
    chk("lw_wb", 32'({bus.MemToReg, bus.RegWrite, bus.RegDst}),
        32'b110);
    tick();

    run_instr(OP_SW, 1'b0, n, saw);
    chk("sw_lat", 32'(n), 32'd4);
    chk("sw_mem", 32'({bus.MemReq, bus.MemWE, bus.IorD}), 32'b111);
    tick();

    run_instr(OP_BEQ, 1'b1, n, saw);
    chk("beq_lat", 32'(n), 32'd3);
    chk("beq_pc", 32'({bus.PCWrite, bus.PCSource}), 32'b11);
    tick();

    run_instr(OP_BNE, 1'b1, n, saw);
    chk("bne_lat", 32'(n), 32'd3);
    chk("bne_pc", 32'({bus.PCWrite, bus.PCSource}), 32'b01);
    tick();
    chk("bne_next", 32'({bus.MemReq, bus.IorD, bus.ALUSrcB}),
        32'b1001);

    run_instr(OP_SHIFT, 1'b1, n, saw);
    chk("sll_lat", 32'(n), 32'd4);
    chk("sll_nopcs", 32'(saw), 32'd0);
    chk("sll_wb", 32'({bus.RegWrite, bus.RegDst}), 32'b11);
    tick();

    bus.Run = 1'b0;
    #1;
    chk("norun_req", 32'({bus.MemReq, bus.IRWrite}), 32'b00);
    tick();
    chk("norun_hold",
        32'({bus.MemReq, bus.IRWrite, bus.ALUSrcB}), 32'b0001);
    bus.Run = 1'b1;

    // LW with three wait cycles in MEM_RD
    bus.OPCODE   = OP_LW;
    bus.MemReady = 1'b1;
    tick();
    tick();
    bus.MemReady = 1'b0;
    tick();
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.MemReady = 1'b1;
      #1;
      if (bus.MemReq && bus.IorD) cnt++;
      if (i < 3) tick();
    end
    chk("lwwait_req", 32'(cnt), 32'd4);
    tick();
    chk("lwwait_wb", 32'({bus.InstrDone, bus.MemToReg, bus.MemReq}),
        32'b110);
    tick();

    // Run drops while a fetch is waiting
    bus.MemReady = 1'b0;
    bus.OPCODE   = OP_ADDI;
    #1;
    chk("fw_req", 32'(bus.MemReq), 32'd1);
    tick();
    bus.Run = 1'b0;
    #1;
    chk("fw_hold", 32'(bus.MemReq), 32'd1);
    tick();
    bus.MemReady = 1'b1;
    #1;
    chk("fw_done", 32'({bus.MemReq, bus.IRWrite}), 32'b11);
    tick();
    chk("fw_dec", 32'(bus.MemReq), 32'd0);
    bus.Run = 1'b1;
    tick();
    tick();
    chk("fw_wb", 32'(bus.InstrDone), 32'd1);
    tick();

    // Fetch timeout: MemReady never arrives
    bus.MemReady = 1'b0;
    cnt = 0;
    #1;
    for (int i = 0; i < 30; i++) begin
      if (!bus.MemReq) break;
      cnt++;
      tick();
    end
    chk("tmo_cycles", 32'(cnt), 32'd16);
    chk("tmo_flags", 32'({bus.BusError, bus.Illegal}), 32'b10);
    bus.MemReady = 1'b1;
    tick();
    tick();
    chk("tmo_hold", 32'(outs), 32'd1);

    Reset_n = 1'b0;
    tick();
    chk("tmo_rst", 32'(outs), 32'd0);
    Reset_n = 1'b1;
    bus.MemReady = 1'b0;
    #1;
    chk("tmo_rel", 32'({bus.MemReq, bus.BusError}), 32'b10);

    // Ready on the 16th request cycle completes normally
    for (int i = 0; i < 15; i++) tick();
    bus.MemReady = 1'b1;
    #1;
    chk("edge_ready", 32'({bus.MemReq, bus.IRWrite}), 32'b11);
    bus.OPCODE = 4'b0100;
    tick();
    chk("edge_noerr", 32'({bus.BusError, bus.MemReq}), 32'b00);

    tick();
    chk("ill_trap", 32'(outs), 32'd2);
    tick();
    tick();
    tick();
    chk("ill_hold", 32'(outs), 32'd2);

    Reset_n = 1'b0;
    tick();
    chk("ill_rst", 32'(outs), 32'd0);
    Reset_n = 1'b1;
    #1;
    chk("ill_rel", 32'({bus.MemReq, bus.IorD, bus.Illegal}),
        32'b100);
    run_instr(OP_RADD, 1'b0, n, saw);
    chk("resume_lat", 32'(n), 32'd4);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle control FSM for the 16-bit CPU. It replaces per-opcode single-cycle decode with a sequenced fetch/decode/execute/memory/writeback flow. One shared instruction/data memory port is used, with a req/ready handshake and a timeout trap. It drives the existing datapath muxes, register file, PC and IR write enables, and the ALU control (ALUOp).

Parameters:
MEM_TIMEOUT, 16, max cycles MemReq may wait for MemReady before bus-error trap; 0 disables timeout
TMR_W, 8, width of the wait counter; must satisfy 2^TMR_W > MEM_TIMEOUT

Ports:
Clock  in  1  single system clock, all state on rising edge
Reset_n  in  1  synchronous, active-low reset
Run  in  1  permits a new instruction fetch
OPCODE  in  4  IR[15:12], valid from DECODE onward
Zero  in  1  ALU zero flag
MemReady  in  1  memory completes current request this cycle
MemReq  out  1  memory request
MemWE  out  1  write qualifier for MemReq
IorD  out  1  0=PC address, 1=ALUOut address
IRWrite  out  1  load instruction register
PCWrite  out  1  load PC
PCSource  out  1  0=ALU result (PC+1), 1=ALUOut (branch target)
ALUSrcA  out  1  0=PC, 1=reg A
ALUSrcB  out  2  00=reg B, 01=const 1, 10=sign-ext imm, 11=branch offset
ALUOp  out  2  00=add, 01=sub/compare, 10=R-type funct, 11=I-type by opcode
RegDst  out  1  1=rd, 0=rt
MemToReg  out  1  1=memory data to register file
RegWrite  out  1  register file write
InstrDone  out  1  one-cycle pulse per retired instruction
Illegal  out  1  sticky: undefined opcode trapped
BusError  out  1  sticky: memory timeout trapped

Behaviour:
- Reset_n=0 at edge: state<=FETCH, counter<=0, Illegal/BusError<=0. While Reset_n is low, all outputs are forced to 0. Reset mid-handshake abandons the request with no write.
- Outputs are Moore decode of state. Exceptions (Mealy): IRWrite, PCWrite, InstrDone qualified by MemReady/Zero as stated below.
- FETCH: MemReq=Run, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - If Run=0, no request is made and the state holds.
  - Once MemReq rises it holds until MemReady, even if Run drops.
  - On MemReady: IRWrite=1, PCWrite=1, PCSource=0, go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (target into ALUOut). Dispatch:
  - 0000/0001/0010 -> EXEC_R
  - 1001/1010/1011 -> EXEC_I
  - 1100/1101 -> ADDR
  - 1111/1110 -> BRANCH
  - others -> TRAP with Illegal<=1
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then WB_R. WB_R: RegDst=1, RegWrite=1, InstrDone=1, then FETCH.
- Shifts (0010) never assert branch behaviour.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11, then WB_I. WB_I: RegDst=0, RegWrite=1, InstrDone=1, then FETCH.
- ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW goes to MEM_RD, SW goes to MEM_WR.
- MEM_RD: MemReq=1, IorD=1. On MemReady go to WB_MEM.
- WB_MEM: MemToReg=1, RegDst=0, RegWrite=1, InstrDone=1, then FETCH.
- MEM_WR: MemReq=1, MemWE=1, IorD=1. On MemReady: InstrDone=1, go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=1.
  - PCWrite = Zero for BEQ, !Zero for BNE.
  - InstrDone=1, then FETCH. Not-taken leaves PC at PC+1.
- Wait counter: cleared on entry to any MemReq state; increments each cycle MemReq=1 && MemReady=0.
  - If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT without MemReady: go to TRAP, BusError<=1, drop MemReq.
  - MemReady in the same cycle the counter hits the limit wins (normal completion).
- TRAP: all control outputs 0. The state holds until reset. Illegal/BusError hold.
- Latencies with zero-wait memory: R/I-type 4 cycles, LW 5, SW 4, branch 3.
- Each memory access adds one cycle per wait cycle.

Decomposition:
- Shared package cpu16_pkg:
  - opcode localparams (OP_RLOG=0000, OP_RADD=0001, OP_SHIFT=0010, OP_ADDI=1001, OP_SUBI=1010, OP_SLTI=1011, OP_LW=1100, OP_SW=1101, OP_BNE=1110, OP_BEQ=1111)
  - ALUOp and ALUSrcB encodings
  - state encoding (FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, TRAP)
- Sub-module mem_wait_timer: clear/enable/expired, parameterized by MEM_TIMEOUT and TMR_W.

Test Plan:
- Reset_n=0 for 2 cycles while MemReady=1 -> all outputs 0. After release with Run=1: MemReq=1 and IorD=0 on the first cycle.
- Zero-wait stream ADDI, LW, SW, BEQ(Zero=1) -> InstrDone pulses spaced 4, 5, 4, 3 cycles. The BEQ cycle shows PCWrite=1 with PCSource=1. LW writeback shows MemToReg=1, RegWrite=1, RegDst=0.
- BNE with Zero=1 -> PCWrite=0 in BRANCH, next FETCH follows. SLL (0010) -> RegWrite in WB_R, no PCSource=1 cycle.
- LW with MemReady delayed 3 cycles in MEM_RD -> MemReq held 4 cycles with IorD=1, WB_MEM one cycle after ready. Deassert Run during FETCH wait -> request still completes.
- MEM_TIMEOUT=16 with MemReady never asserted -> MemReq drops after 16 wait cycles, BusError=1 stays. MemReady exactly at cycle 16 -> normal completion, no BusError.
- OPCODE=0100 -> TRAP after DECODE, Illegal=1 and no further MemReq until Reset_n low. After reset, a normal fetch resumes.
